// File: rtl/ble_tx_sched_pkg.sv
// Shared types and constants for the BLE TX FIFO write-port scheduler.
package ble_tx_sched_pkg;

  localparam int SW_DEF = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  // Index of each requester inside the one-hot grant vector.
  localparam logic GNT_IDX_HDR = 1'b0;
  localparam logic GNT_IDX_DMA = 1'b1;

endpackage

// File: rtl/ble_rr_arbiter2.sv
// Two-input round-robin arbiter. Purely combinational; the pointer
// register lives in the parent so the pointer only moves on packet end.
module ble_rr_arbiter2
  import ble_tx_sched_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       rr_ptr_i,
  input  logic       arb_en_i,
  output logic [1:0] gnt_o
);

  // Favour the requester named by the pointer, else take the other one.
  always_comb begin
    gnt_o = 2'b00;
    if (arb_en_i) begin
      if (rr_ptr_i == GNT_IDX_DMA) begin
        gnt_o = req_i[1] ? 2'b10 : {1'b0, req_i[0]};
      end else begin
        gnt_o = req_i[0] ? 2'b01 : {req_i[1], 1'b0};
      end
    end
  end

endmodule

// File: rtl/ble_tx_fifo_sched.sv
// Packet-level scheduler for the BLE PHY TX FIFO write port.
// Grants whole packets round-robin between the header source (req0) and the
// payload DMA (req1), streams words into the FIFO, stalls on FULL and pulses
// tx_irq when a packet completes.
// Optional: define BLE_TXSCHED_TIMEOUT_EN to abort a packet that stalls for
// TIMEOUT_CYC cycles (tx_abort pulses instead of tx_irq).
module ble_tx_fifo_sched
  import ble_tx_sched_pkg::*;
#(
  parameter int DW          = 32,
  parameter int SW          = SW_DEF,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic          W_CLK,
  input  logic          W_RST,
  input  logic          req0,
  input  logic          req1,
  input  logic [SW-1:0] size0,
  input  logic [SW-1:0] size1,
  input  logic [DW-1:0] data0,
  input  logic [DW-1:0] data1,
  input  logic          valid0,
  input  logic          valid1,
  output logic          ready0,
  output logic          ready1,
  input  logic          fifo_full,
  output logic          fifo_winc,
  output logic [DW-1:0] fifo_wdata,
  output logic [SW-1:0] fifo_data_size,
  output logic [SW-1:0] fifo_waddr_bits,
  output logic [1:0]    grant,
  output logic          busy,
  output logic          tx_irq,
  output logic          tx_abort
);

  sched_state_e  state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] size_q, size_d;
  logic          rr_q, rr_d;
  logic [1:0]    arb_gnt;
  logic          valid_g;
  logic [DW-1:0] data_g;

`ifdef BLE_TXSCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] STALL_LIM = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] stall_q, stall_d;
  logic          abort_q, abort_d;
`endif

  ble_rr_arbiter2 u_arb (
    .req_i    ({req1, req0}),
    .rr_ptr_i (rr_q),
    .arb_en_i (state_q == IDLE),
    .gnt_o    (arb_gnt)
  );

  assign valid_g = grant_q[1] ? valid1 : valid0;
  assign data_g  = grant_q[1] ? data1  : data0;

  // Next-state and FIFO-side outputs; the partial packet is never rewound.
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    cnt_d           = cnt_q;
    size_d          = size_q;
    rr_d            = rr_q;
    ready0          = 1'b0;
    ready1          = 1'b0;
    fifo_winc       = 1'b0;
    fifo_wdata      = '0;
    tx_irq          = 1'b0;
    tx_abort        = 1'b0;
    busy            = (state_q == LOAD) || (state_q == DONE);
    fifo_data_size  = busy ? size_q : '0;
    fifo_waddr_bits = cnt_q;
    grant           = grant_q;
`ifdef BLE_TXSCHED_TIMEOUT_EN
    stall_d         = stall_q;
    abort_d         = abort_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          grant_d = arb_gnt;
          size_d  = arb_gnt[1] ? size1 : size0;
          cnt_d   = '0;
          state_d = LOAD;
`ifdef BLE_TXSCHED_TIMEOUT_EN
          stall_d = '0;
          abort_d = 1'b0;
`endif
        end
      end
      LOAD: begin
        ready0     = grant_q[0] & ~fifo_full;
        ready1     = grant_q[1] & ~fifo_full;
        fifo_winc  = valid_g & ~fifo_full;
        fifo_wdata = data_g;
        if (fifo_winc) begin
          // Terminal compare before the increment keeps cnt in range at 2^SW-1.
          if (cnt_q == size_q) state_d = DONE;
          else                 cnt_d   = cnt_q + 1'b1;
`ifdef BLE_TXSCHED_TIMEOUT_EN
          stall_d = '0;
        end else if (stall_q == STALL_LIM) begin
          state_d = DONE;
          abort_d = 1'b1;
        end else begin
          stall_d = stall_q + 1'b1;
`endif
        end
      end
      DONE: begin
`ifdef BLE_TXSCHED_TIMEOUT_EN
        tx_irq   = ~abort_q;
        tx_abort = abort_q;
`else
        tx_irq   = 1'b1;
`endif
        rr_d    = grant_q[0];
        grant_d = 2'b00;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and packet registers; reset discards any packet in flight.
  always_ff @(posedge W_CLK or posedge W_RST) begin
    if (W_RST) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      cnt_q   <= '0;
      size_q  <= '0;
      rr_q    <= GNT_IDX_HDR;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      rr_q    <= rr_d;
    end
  end

`ifdef BLE_TXSCHED_TIMEOUT_EN
  // Stall watchdog: counts LOAD cycles without a transfer.
  always_ff @(posedge W_CLK or posedge W_RST) begin
    if (W_RST) begin
      stall_q <= '0;
      abort_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
      abort_q <= abort_d;
    end
  end
`endif

endmodule

// File: tb/tb_ble_tx_fifo_sched.sv
// Directed and randomized bench for ble_tx_fifo_sched.
module tb_ble_tx_fifo_sched;

  localparam int DW = 32;
  localparam int SW = 17;
  localparam int NP = 6;

  logic          W_CLK = 1'b0;
  logic          W_RST;
  logic          req0, req1, valid0, valid1, fifo_full;
  logic [SW-1:0] size0, size1;
  logic [DW-1:0] data0, data1;
  logic          ready0, ready1, fifo_winc, busy, tx_irq, tx_abort;
  logic [DW-1:0] fifo_wdata;
  logic [SW-1:0] fifo_data_size, fifo_waddr_bits;
  logic [1:0]    grant;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          s;
    logic [SW-1:0] a;
    logic [SW-1:0] d;
    logic [DW-1:0] w;
  } wr_t;

  wr_t           expq[$];
  logic [SW-1:0] rsz[2][NP];
  logic [DW-1:0] rwd[2][NP][6];

  ble_tx_fifo_sched #(.DW(DW), .SW(SW), .TIMEOUT_CYC(8)) dut (
    .W_CLK(W_CLK), .W_RST(W_RST),
    .req0(req0), .req1(req1), .size0(size0), .size1(size1),
    .data0(data0), .data1(data1), .valid0(valid0), .valid1(valid1),
    .ready0(ready0), .ready1(ready1), .fifo_full(fifo_full),
    .fifo_winc(fifo_winc), .fifo_wdata(fifo_wdata),
    .fifo_data_size(fifo_data_size), .fifo_waddr_bits(fifo_waddr_bits),
    .grant(grant), .busy(busy), .tx_irq(tx_irq), .tx_abort(tx_abort)
  );

  always #5 W_CLK = ~W_CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge W_CLK);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdy"},   {ready0, ready1}, 0);
    chk({tag, "_winc"},  fifo_winc, 0);
    chk({tag, "_wdata"}, fifo_wdata, 0);
    chk({tag, "_dsz"},   fifo_data_size, 0);
    chk({tag, "_addr"},  fifo_waddr_bits, 0);
    chk({tag, "_gnt"},   grant, 0);
    chk({tag, "_flags"}, {busy, tx_irq, tx_abort}, 0);
  endtask

  initial begin
    int w, fc, p0, p1, cyc, stall;
    int pk[2];
    int wi[2];
    bit seen, term_prev, term, frc;
    int st_c[$];
    logic st_s[$];
    wr_t e;

    W_RST = 1'b1;
    {req0, req1, valid0, valid1, fifo_full} = '0;
    size0 = '0; size1 = '0; data0 = '0; data1 = '0;
    #1;
    chk_zero("rst");
    step();
    W_RST = 1'b0;

    // D1: four-word packet from req0
    req0 = 1'b1; size0 = 3; valid0 = 1'b1; data0 = 32'hA000_0000;
    step();
    req0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data0 = 32'hA000_0000 + i;
      #1;
      chk("d1_winc", fifo_winc, 1);
      chk("d1_addr", fifo_waddr_bits, i);
      chk("d1_data", fifo_wdata, 32'hA000_0000 + i);
      chk("d1_dsz", fifo_data_size, 3);
      chk("d1_gnt", grant, 2'b01);
      chk("d1_rdy", {ready1, ready0}, 2'b01);
      chk("d1_irq_early", tx_irq, 0);
      step();
    end
    chk("d1_irq", tx_irq, 1);
    chk("d1_done_winc", fifo_winc, 0);
    chk("d1_done_dsz", fifo_data_size, 3);
    chk("d1_done_gnt", grant, 2'b01);
    step();
    chk("d1_idle_irq", tx_irq, 0);
    chk("d1_idle_dsz", fifo_data_size, 0);
    step();
    chk("d1_nogrant", {grant, busy}, 0);

    // D2: both requesters, expect 0,1,0 with minimum gaps
    W_RST = 1'b1; step(); W_RST = 1'b0;
    req0 = 1'b1; size0 = 1; req1 = 1'b1; size1 = 2;
    valid0 = 1'b1; valid1 = 1'b1; data0 = 32'h1111_1111; data1 = 32'h2222_2222;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (busy) chk("d2_rdy_ng", grant[0] ? ready1 : ready0, 0);
      if (fifo_winc) chk("d2_data", fifo_wdata, grant[1] ? 32'h2222_2222 : 32'h1111_1111);
      if (fifo_winc && fifo_waddr_bits == 0) begin
        st_c.push_back(c);
        st_s.push_back(grant[1]);
        if (st_c.size() == 2) req1 = 1'b0;
        if (st_c.size() == 3) req0 = 1'b0;
      end
      step();
    end
    chk("d2_npkts", st_c.size(), 3);
    if (st_c.size() >= 3) begin
      chk("d2_order", {st_s[0], st_s[1], st_s[2]}, 3'b010);
      chk("d2_gap01", st_c[1] - st_c[0], 4);
      chk("d2_gap12", st_c[2] - st_c[1], 5);
    end

    // D3: FIFO full for 5 cycles at cnt=2 of a 5-word packet
    req0 = 1'b1; size0 = 4; valid0 = 1'b1;
    step();
    req0 = 1'b0;
    w = 0; fc = 0; seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      fifo_full = (w == 2 && fc < 5);
      #1;
      if (tx_irq) begin
        seen = 1'b1;
      end else if (fifo_full) begin
        chk("d3_full_winc", fifo_winc, 0);
        chk("d3_full_rdy", ready0, 0);
        chk("d3_full_addr", fifo_waddr_bits, 2);
        fc++;
      end else begin
        chk("d3_winc", fifo_winc, 1);
        chk("d3_addr", fifo_waddr_bits, w);
        w++;
      end
      step();
    end
    fifo_full = 1'b0;
    chk("d3_irq_seen", seen, 1);
    chk("d3_writes", w, 5);
    chk("d3_stalls", fc, 5);

    // D4: single-word packet from req1
    req1 = 1'b1; size1 = 0; valid1 = 1'b1; data1 = 32'h0000_BEEF;
    step();
    req1 = 1'b0;
    #1;
    chk("d4_gnt", grant, 2'b10);
    chk("d4_winc", fifo_winc, 1);
    chk("d4_addr", fifo_waddr_bits, 0);
    chk("d4_data", fifo_wdata, 32'h0000_BEEF);
    chk("d4_rdy", {ready1, ready0}, 2'b10);
    step();
    chk("d4_irq", tx_irq, 1);
    step();
    chk("d4_idle", {tx_irq, busy}, 0);

    // D5: reset in the middle of an 8-word packet
    req0 = 1'b1; size0 = 7; valid0 = 1'b1;
    step();
    req0 = 1'b0;
    step(); step(); step();
    chk("d5_addr3", fifo_waddr_bits, 3);
    W_RST = 1'b1;
    #1;
    chk_zero("d5_rst");
    step();
    chk_zero("d5_rst_hold");
    W_RST = 1'b0;
    req1 = 1'b1; size1 = 1; valid1 = 1'b1; data1 = 32'h5555_0000;
    step();
    req1 = 1'b0;
    #1;
    chk("d5_gnt", grant, 2'b10);
    chk("d5_addr0", fifo_waddr_bits, 0);
    chk("d5_winc", fifo_winc, 1);
    step();
    chk("d5_addr1", fifo_waddr_bits, 1);
    step();
    chk("d5_irq", tx_irq, 1);
    step();

    // D6: source stalls with valid low
    req0 = 1'b1; size0 = 3; valid0 = 1'b0;
    step();
    req0 = 1'b0; req1 = 1'b1; size1 = 0; valid1 = 1'b1;
    #1;
`ifdef BLE_TXSCHED_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      chk("d6_abort_early", tx_abort, 0);
      chk("d6_busy", busy, 1);
      chk("d6_winc", fifo_winc, 0);
      step();
    end
    chk("d6_abort", tx_abort, 1);
    chk("d6_no_irq", tx_irq, 0);
`else
    for (int i = 0; i < 10; i++) begin
      chk("d6_abort0", tx_abort, 0);
      chk("d6_hold_gnt", grant, 2'b01);
      chk("d6_busy", busy, 1);
      chk("d6_winc", fifo_winc, 0);
      step();
    end
    valid0 = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("d6_resume_addr", fifo_waddr_bits, i);
      step();
    end
    chk("d6_irq", tx_irq, 1);
    chk("d6_abort_done", tx_abort, 0);
`endif
    step(); step();
    chk("d6_next_gnt", grant, 2'b10);
    req1 = 1'b0;
    step(); step();

    // Randomized phase: both sources always requesting, packets alternate
    W_RST = 1'b1; step(); W_RST = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int p = 0; p < NP; p++) begin
        rsz[s][p] = SW'($urandom_range(0, 5));
        for (int k = 0; k < 6; k++) rwd[s][p][k] = $urandom;
      end
    for (int k = 0; k < 2 * NP; k++)
      for (int a = 0; a <= int'(rsz[k % 2][k / 2]); a++) begin
        e.s = 1'(k % 2); e.a = SW'(a); e.d = rsz[k % 2][k / 2]; e.w = rwd[k % 2][k / 2][a];
        expq.push_back(e);
      end
    pk[0] = 0; pk[1] = 0; wi[0] = 0; wi[1] = 0;
    stall = 0; term_prev = 1'b0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (expq.size() == 0 && !busy && pk[0] == NP && pk[1] == NP) break;
      p0 = (pk[0] < NP) ? pk[0] : 0;
      p1 = (pk[1] < NP) ? pk[1] : 0;
      frc = (stall >= 5);
      req0 = (pk[0] < NP); size0 = rsz[0][p0]; data0 = rwd[0][p0][wi[0]];
      req1 = (pk[1] < NP); size1 = rsz[1][p1]; data1 = rwd[1][p1][wi[1]];
      valid0 = frc || ($urandom_range(0, 3) != 0);
      valid1 = frc || ($urandom_range(0, 3) != 0);
      fifo_full = !frc && ($urandom_range(0, 4) == 0);
      #1;
      if (busy) chk("r_rdy_ng", grant[0] ? ready1 : ready0, 0);
      chk("r_irq", tx_irq, term_prev);
      chk("r_abort", tx_abort, 0);
      term = 1'b0;
      if (fifo_winc) begin
        chk("r_winc_full", fifo_full, 0);
        if (expq.size() == 0) begin
          chk("r_extra_write", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("r_src", grant, e.s ? 2'b10 : 2'b01);
          chk("r_addr", fifo_waddr_bits, e.a);
          chk("r_dsz", fifo_data_size, e.d);
          chk("r_data", fifo_wdata, e.w);
          term = (e.a == e.d);
          if (!term) wi[e.s] = wi[e.s] + 1;
        end
        stall = 0;
      end else if (busy && !tx_irq) begin
        stall++;
      end
      if (tx_irq) begin
        pk[grant[1]] = pk[grant[1]] + 1;
        wi[grant[1]] = 0;
        stall = 0;
      end
      term_prev = term;
      step();
    end
    chk("r_all_written", expq.size(), 0);
    chk("r_in_budget", cyc < 3000, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
